// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store sequencer between the core memory stage and byte-addressed data memory
//
// Accepts one load or store per request handshake. Drives the memory's
// address, size, write data and active-low write enable, waits for LATENCY
// extra cycles, and returns sign- or zero-extended load data on the response
// handshake. Misaligned accesses and size 2'b11 are answered with an error
// response and never reach memory.
//
// Ports
//   CLK, RST                 clock, synchronous active-high reset
//   req_valid / req_ready    request handshake (ready only while idle)
//   req_wen                  1 = store, 0 = load
//   req_size                 00 byte, 01 halfword, 10 word, 11 illegal
//   req_unsigned             loads: 1 = zero-extend, 0 = sign-extend
//   req_addr, req_wdata      byte address, right-aligned store data
//   req_rd                   destination tag echoed on the response
//   resp_valid / resp_ready  response handshake
//   resp_data, resp_err      extended load data (0 for stores/errors), error flag
//   resp_rd                  echoed tag
//   mem_addr, mem_size       memory Addr / Size, held for the whole access
//   mem_wdata                memory DataIn with unused lanes zeroed
//   mem_wen_n                memory WEN, low only in a store's commit cycle
//   mem_rdata                memory DataOut (byte replicated x4, halfword x2)

module mem_access_unit #(
    parameter int unsigned LATENCY = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        resp_err,
    output logic [4:0]  resp_rd,
    output logic [31:0] mem_addr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_wdata,
    output logic        mem_wen_n,
    input  logic [31:0] mem_rdata
);

    localparam logic [3:0] LP_LATENCY = 4'(LATENCY);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [3:0]  r_cnt;
    logic        r_wen;
    logic        r_unsigned;
    logic [31:0] r_mem_addr;
    logic [1:0]  r_mem_size;
    logic [31:0] r_mem_wdata;
    logic [31:0] r_resp_data;
    logic        r_resp_err;
    logic [4:0]  r_resp_rd;

    logic        w_req_bad;
    logic        w_accept;
    logic        w_commit;
    logic [31:0] w_wdata_lanes;
    logic [31:0] w_load_data;

    // Alignment / size legality of the request currently presented.
    always_comb begin
        w_req_bad = 1'b0;
        case (req_size)
            2'b00:   w_req_bad = 1'b0;
            2'b01:   w_req_bad = req_addr[0];
            2'b10:   w_req_bad = (req_addr[1:0] != 2'b00);
            default: w_req_bad = 1'b1;
        endcase
    end

    // Store data with lanes beyond the access size forced to zero.
    always_comb begin
        w_wdata_lanes = req_wdata;
        case (req_size)
            2'b00:   w_wdata_lanes = {24'd0, req_wdata[7:0]};
            2'b01:   w_wdata_lanes = {16'd0, req_wdata[15:0]};
            default: w_wdata_lanes = req_wdata;
        endcase
    end

    // Memory replicates narrow reads across the bus, so the low lanes
    // always carry the addressed data and no byte-lane shifting is needed.
    always_comb begin
        w_load_data = mem_rdata;
        case (r_mem_size)
            2'b00:   w_load_data = {{24{mem_rdata[7]  & ~r_unsigned}}, mem_rdata[7:0]};
            2'b01:   w_load_data = {{16{mem_rdata[15] & ~r_unsigned}}, mem_rdata[15:0]};
            default: w_load_data = mem_rdata;
        endcase
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and handshake / strobe outputs.
    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        w_accept    = 1'b0;
        w_commit    = 1'b0;
        mem_wen_n   = 1'b1;
        case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = w_req_bad ? ST_RESP : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (r_cnt == 4'd0) begin
                    w_commit    = 1'b1;
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        // Gated by RST so a store whose commit cycle is being reset never
        // reaches the falling-edge write in memory.
        mem_wen_n = ~(w_commit & r_wen & ~RST);
    end

    // Request capture, wait counter and response datapath.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt       <= 4'd0;
            r_wen       <= 1'b0;
            r_unsigned  <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_size  <= 2'b00;
            r_mem_wdata <= 32'd0;
            r_resp_data <= 32'd0;
            r_resp_err  <= 1'b0;
            r_resp_rd   <= 5'd0;
        end else begin
            if (w_accept) begin
                r_resp_rd  <= req_rd;
                r_wen      <= req_wen;
                r_unsigned <= req_unsigned;
                if (w_req_bad) begin
                    // Rejected: memory pins keep their previous values.
                    r_resp_err  <= 1'b1;
                    r_resp_data <= 32'd0;
                end else begin
                    r_resp_err  <= 1'b0;
                    r_resp_data <= 32'd0;
                    r_mem_addr  <= req_addr;
                    r_mem_size  <= req_size;
                    r_mem_wdata <= w_wdata_lanes;
                    r_cnt       <= LP_LATENCY;
                end
            end else if (r_state == ST_ACCESS) begin
                if (w_commit) begin
                    r_resp_data <= r_wen ? 32'd0 : w_load_data;
                end else begin
                    r_cnt <= r_cnt - 4'd1;
                end
            end
        end
    end

    assign resp_data = r_resp_data;
    assign resp_err  = r_resp_err;
    assign resp_rd   = r_resp_rd;
    assign mem_addr  = r_mem_addr;
    assign mem_size  = r_mem_size;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench for mem_access_unit (LATENCY 1 and 3 instances)
`timescale 1ns/1ps

module tb_mem_access_unit;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        mem_init = 1'b0;

    logic        req_valid_i  [2];
    logic        resp_ready_i [2];
    logic        req_wen;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;

    logic        req_ready_o  [2];
    logic        resp_valid_o [2];
    logic [31:0] resp_data_o  [2];
    logic        resp_err_o   [2];
    logic [4:0]  resp_rd_o    [2];
    logic [31:0] mem_addr_o   [2];
    logic [1:0]  mem_size_o   [2];
    logic [31:0] mem_wdata_o  [2];
    logic        mem_wen_n_o  [2];
    logic [31:0] mem_rdata_i  [2];

    logic [7:0]  init_val [256];
    logic [7:0]  env_mem  [512];
    logic [7:0]  ref_mem  [2][256];
    int          ra [2];

    int n_vec = 0;
    int n_bad = 0;

    int          obs_lat;
    int          obs_wen_lows;
    int          obs_wen_at;
    logic [65:0] obs_bus_first;
    logic [65:0] obs_bus_last;
    logic [31:0] obs_data;
    logic        obs_err;
    logic [4:0]  obs_rd;

    always #5 CLK = ~CLK;

    mem_access_unit #(.LATENCY(1)) u_dut_l1 (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid_i[0]), .req_ready(req_ready_o[0]),
        .req_wen(req_wen), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .resp_valid(resp_valid_o[0]), .resp_ready(resp_ready_i[0]),
        .resp_data(resp_data_o[0]), .resp_err(resp_err_o[0]), .resp_rd(resp_rd_o[0]),
        .mem_addr(mem_addr_o[0]), .mem_size(mem_size_o[0]), .mem_wdata(mem_wdata_o[0]),
        .mem_wen_n(mem_wen_n_o[0]), .mem_rdata(mem_rdata_i[0])
    );

    mem_access_unit #(.LATENCY(3)) u_dut_l3 (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid_i[1]), .req_ready(req_ready_o[1]),
        .req_wen(req_wen), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .resp_valid(resp_valid_o[1]), .resp_ready(resp_ready_i[1]),
        .resp_data(resp_data_o[1]), .resp_err(resp_err_o[1]), .resp_rd(resp_rd_o[1]),
        .mem_addr(mem_addr_o[1]), .mem_size(mem_size_o[1]), .mem_wdata(mem_wdata_o[1]),
        .mem_wen_n(mem_wen_n_o[1]), .mem_rdata(mem_rdata_i[1])
    );

    // Data memories: instance d owns env_mem[d*256 +: 256].
    always_comb begin
        for (int d = 0; d < 2; d++) begin
            ra[d] = d * 256 + int'(mem_addr_o[d][7:0]);
            case (mem_size_o[d])
                2'b00:   mem_rdata_i[d] = {4{env_mem[ra[d]]}};
                2'b01:   mem_rdata_i[d] = {2{env_mem[ra[d] + 1], env_mem[ra[d]]}};
                default: mem_rdata_i[d] = {env_mem[ra[d] + 3], env_mem[ra[d] + 2],
                                           env_mem[ra[d] + 1], env_mem[ra[d]]};
            endcase
        end
    end

    always @(negedge CLK) begin
        if (mem_init) begin
            for (int i = 0; i < 512; i++) env_mem[i] <= init_val[i % 256];
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (!mem_wen_n_o[d]) begin
                    for (int b = 0; b < (1 << mem_size_o[d]); b++)
                        env_mem[d * 256 + int'(mem_addr_o[d][7:0]) + b] <= 8'(mem_wdata_o[d] >> (8 * b));
                end
            end
        end
    end

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic logic model_err(input logic [1:0] sz, input logic [31:0] a);
        return (sz == 2'b11) || ((a % (32'd1 << sz)) != 0);
    endfunction

    function automatic logic [31:0] model_load(input int d, input logic [1:0] sz, input logic u, input logic [7:0] a);
        logic [31:0] v;
        int nb;
        nb = 1 << sz;
        v = 0;
        for (int i = 0; i < nb; i++) v = v + (32'(ref_mem[d][(int'(a) + i) % 256]) << (8 * i));
        if (!u && nb < 4 && v >= (32'd1 << (8 * nb - 1))) v = v - (32'd1 << (8 * nb));
        return v;
    endfunction

    function automatic logic [31:0] model_lanes(input logic [1:0] sz, input logic [31:0] wd);
        if (sz == 2'b10) return wd;
        return wd & ((32'd1 << (8 * (1 << sz))) - 32'd1);
    endfunction

    task automatic model_store(input int d, input logic [1:0] sz, input logic [7:0] a, input logic [31:0] wd);
        for (int i = 0; i < (1 << sz); i++) ref_mem[d][int'(a) + i] = 8'(wd >> (8 * i));
    endtask

    // Present one request, wait for its response and record what was seen.
    task automatic issue(input int d, input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
        int lat;
        req_wen = w; req_size = sz; req_unsigned = u;
        req_addr = a; req_wdata = wd; req_rd = rd;
        req_valid_i[d] = 1'b1;
        @(posedge CLK); #1;
        req_valid_i[d] = 1'b0;
        lat = 0; obs_wen_lows = 0; obs_wen_at = 0;
        obs_bus_first = '0; obs_bus_last = '0;
        while (!resp_valid_o[d] && lat < 40) begin
            if (lat == 0) obs_bus_first = {mem_addr_o[d], mem_size_o[d], mem_wdata_o[d]};
            obs_bus_last = {mem_addr_o[d], mem_size_o[d], mem_wdata_o[d]};
            if (!mem_wen_n_o[d]) begin
                obs_wen_lows++;
                obs_wen_at = lat + 1;
            end
            @(posedge CLK); #1;
            lat++;
        end
        obs_lat = lat; obs_data = resp_data_o[d]; obs_err = resp_err_o[d]; obs_rd = resp_rd_o[d];
    endtask

    task automatic handshake(input int d);
        resp_ready_i[d] = 1'b1;
        @(posedge CLK); #1;
        resp_ready_i[d] = 1'b0;
    endtask

    task automatic test_reset;
        RST = 1'b1; mem_init = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        for (int d = 0; d < 2; d++) begin
            n_vec++;
            if ({req_ready_o[d], resp_valid_o[d], resp_err_o[d], mem_wen_n_o[d]} !== 4'b1001) begin
                n_bad++;
                $display("FAIL reset_flags[%0d]: got %b want 1001", d,
                         {req_ready_o[d], resp_valid_o[d], resp_err_o[d], mem_wen_n_o[d]});
            end
            n_vec++;
            if ({resp_data_o[d], resp_rd_o[d], mem_addr_o[d], mem_size_o[d], mem_wdata_o[d]} !== '0) begin
                n_bad++;
                $display("FAIL reset_values[%0d]: data %h rd %h addr %h size %h wdata %h want all 0", d,
                         resp_data_o[d], resp_rd_o[d], mem_addr_o[d], mem_size_o[d], mem_wdata_o[d]);
            end
        end
        mem_init = 1'b0; RST = 1'b0;
        @(posedge CLK); #1;
    endtask

    task automatic test_store_word;
        issue(0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 5'd3);
        model_store(0, 2'b10, 8'h10, 32'hDEADBEEF);
        n_vec++;
        if (obs_wen_lows !== 1 || obs_wen_at !== 2) begin
            n_bad++;
            $display("FAIL store_wen: got %0d low cycles at access cycle %0d want 1 at 2", obs_wen_lows, obs_wen_at);
        end
        n_vec++;
        if (obs_bus_last !== {32'h10, 2'b10, 32'hDEADBEEF}) begin
            n_bad++;
            $display("FAIL store_bus: got %h want %h", obs_bus_last, {32'h10, 2'b10, 32'hDEADBEEF});
        end
        n_vec++;
        if ({env_mem[8'h13], env_mem[8'h12], env_mem[8'h11], env_mem[8'h10]} !== 32'hDEADBEEF) begin
            n_bad++;
            $display("FAIL store_mem: got %h want deadbeef",
                     {env_mem[8'h13], env_mem[8'h12], env_mem[8'h11], env_mem[8'h10]});
        end
        n_vec++;
        if (obs_lat !== 2 || obs_data !== 32'd0 || obs_err !== 1'b0) begin
            n_bad++;
            $display("FAIL store_resp: got lat %0d data %h err %b want 2 0 0", obs_lat, obs_data, obs_err);
        end
        handshake(0);
    endtask

    task automatic test_load_ext;
        issue(0, 1'b0, 2'b00, 1'b0, 32'h12, 32'hFFFFFFFF, 5'd7);
        n_vec++;
        if (obs_data !== 32'hFFFFFFAD || obs_rd !== 5'd7 || obs_lat !== 2) begin
            n_bad++;
            $display("FAIL load_byte_s: got %h rd %0d lat %0d want ffffffad 7 2", obs_data, obs_rd, obs_lat);
        end
        handshake(0);
        issue(0, 1'b0, 2'b00, 1'b1, 32'h12, 32'h0, 5'd7);
        n_vec++;
        if (obs_data !== 32'h000000AD || obs_wen_lows !== 0) begin
            n_bad++;
            $display("FAIL load_byte_u: got %h wen_lows %0d want 000000ad 0", obs_data, obs_wen_lows);
        end
        handshake(0);
        issue(0, 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 5'd21);
        n_vec++;
        if (obs_data !== 32'hFFFFDEAD || obs_rd !== 5'd21) begin
            n_bad++;
            $display("FAIL load_half_s: got %h rd %0d want ffffdead 21", obs_data, obs_rd);
        end
        handshake(0);
    endtask

    task automatic test_errors;
        issue(0, 1'b0, 2'b10, 1'b0, 32'h11, 32'h0, 5'd2);
        n_vec++;
        if (obs_err !== 1'b1 || obs_data !== 32'd0 || obs_lat !== 0 || obs_wen_lows !== 0) begin
            n_bad++;
            $display("FAIL err_misaligned: got err %b data %h lat %0d wen_lows %0d want 1 0 0 0",
                     obs_err, obs_data, obs_lat, obs_wen_lows);
        end
        handshake(0);
        issue(0, 1'b1, 2'b11, 1'b0, 32'h10, 32'h12345678, 5'd30);
        n_vec++;
        if (obs_err !== 1'b1 || obs_data !== 32'd0 || obs_lat !== 0 || obs_wen_lows !== 0 || obs_rd !== 5'd30) begin
            n_bad++;
            $display("FAIL err_size3: got err %b data %h lat %0d wen_lows %0d rd %0d want 1 0 0 0 30",
                     obs_err, obs_data, obs_lat, obs_wen_lows, obs_rd);
        end
        handshake(0);
        n_vec++;
        if ({env_mem[8'h13], env_mem[8'h12], env_mem[8'h11], env_mem[8'h10]} !== 32'hDEADBEEF) begin
            n_bad++;
            $display("FAIL err_mem_untouched: got %h want deadbeef",
                     {env_mem[8'h13], env_mem[8'h12], env_mem[8'h11], env_mem[8'h10]});
        end
    endtask

    task automatic test_hold;
        logic [31:0] held;
        int lat;
        issue(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 5'd9);
        held = obs_data;
        n_vec++;
        if (held !== 32'hDEADBEEF) begin
            n_bad++;
            $display("FAIL hold_first: got %h want deadbeef", held);
        end
        req_wen = 1'b0; req_size = 2'b00; req_unsigned = 1'b1; req_addr = 32'h13; req_rd = 5'd12;
        req_valid_i[0] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge CLK); #1;
            n_vec++;
            if (resp_valid_o[0] !== 1'b1 || resp_data_o[0] !== 32'hDEADBEEF || req_ready_o[0] !== 1'b0 || resp_rd_o[0] !== 5'd9) begin
                n_bad++;
                $display("FAIL hold_stable[%0d]: got valid %b data %h ready %b rd %0d want 1 deadbeef 0 9",
                         c, resp_valid_o[0], resp_data_o[0], req_ready_o[0], resp_rd_o[0]);
            end
        end
        resp_ready_i[0] = 1'b1;
        @(posedge CLK); #1;
        resp_ready_i[0] = 1'b0;
        n_vec++;
        if (resp_valid_o[0] !== 1'b0 || req_ready_o[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL hold_release: got valid %b ready %b want 0 1", resp_valid_o[0], req_ready_o[0]);
        end
        @(posedge CLK); #1;
        req_valid_i[0] = 1'b0;
        lat = 0;
        while (!resp_valid_o[0] && lat < 20) begin
            @(posedge CLK); #1;
            lat++;
        end
        n_vec++;
        if (lat !== 2 || resp_data_o[0] !== 32'h000000DE || resp_rd_o[0] !== 5'd12) begin
            n_bad++;
            $display("FAIL hold_second: got lat %0d data %h rd %0d want 2 000000de 12", lat, resp_data_o[0], resp_rd_o[0]);
        end
        handshake(0);
    endtask

    task automatic test_reset_commit;
        issue_setup_store();
        repeat (3) begin
            @(posedge CLK); #1;
        end
        n_vec++;
        if (mem_wen_n_o[1] !== 1'b0) begin
            n_bad++;
            $display("FAIL rstc_commit_cycle: got wen_n %b want 0", mem_wen_n_o[1]);
        end
        RST = 1'b1;
        #1;
        n_vec++;
        if (mem_wen_n_o[1] !== 1'b1) begin
            n_bad++;
            $display("FAIL rstc_wen_gated: got wen_n %b want 1", mem_wen_n_o[1]);
        end
        @(posedge CLK); #1;
        n_vec++;
        if ({req_ready_o[1], resp_valid_o[1], resp_err_o[1], mem_wen_n_o[1]} !== 4'b1001 ||
            {resp_data_o[1], resp_rd_o[1], mem_addr_o[1], mem_size_o[1], mem_wdata_o[1]} !== '0) begin
            n_bad++;
            $display("FAIL rstc_values: ready %b valid %b err %b wen_n %b data %h rd %h addr %h size %h wdata %h want 1 0 0 1 and zeros",
                     req_ready_o[1], resp_valid_o[1], resp_err_o[1], mem_wen_n_o[1],
                     resp_data_o[1], resp_rd_o[1], mem_addr_o[1], mem_size_o[1], mem_wdata_o[1]);
        end
        RST = 1'b0;
        @(posedge CLK); #1;
        n_vec++;
        if (env_mem[256 + 8'h20] !== ref_mem[1][8'h20] || env_mem[256 + 8'h20] === 8'h55) begin
            n_bad++;
            $display("FAIL rstc_mem: got %h want %h", env_mem[256 + 8'h20], ref_mem[1][8'h20]);
        end
    endtask

    task automatic issue_setup_store;
        req_wen = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h20; req_wdata = 32'h55; req_rd = 5'd4;
        req_valid_i[1] = 1'b1;
        @(posedge CLK); #1;
        req_valid_i[1] = 1'b0;
    endtask

    task automatic test_random;
        for (int t = 0; t < 60; t++) begin
            int d;
            logic w, u, e;
            logic [1:0] sz;
            logic [31:0] a, wd, exp_data;
            logic [4:0] rd;
            d  = int'($urandom_range(0, 1));
            w  = 1'($urandom);
            u  = 1'($urandom);
            sz = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            a  = 32'($urandom_range(0, 255)) | ($urandom & 32'hFFFF_FF00);
            if ($urandom_range(0, 3) != 0 && sz != 2'b11) a = a & ~((32'd1 << sz) - 1);
            wd = $urandom;
            rd = 5'($urandom);
            e  = model_err(sz, a);
            exp_data = (e || w) ? 32'd0 : model_load(d, sz, u, a[7:0]);
            issue(d, w, sz, u, a, wd, rd);
            if (!e && w) model_store(d, sz, a[7:0], wd);
            n_vec++;
            if (obs_lat !== (e ? 0 : lat_of(d) + 1) || obs_err !== e || obs_data !== exp_data || obs_rd !== rd) begin
                n_bad++;
                $display("FAIL rand_resp[%0d]: got lat %0d err %b data %h rd %0d want %0d %b %h %0d", t,
                         obs_lat, obs_err, obs_data, obs_rd, e ? 0 : lat_of(d) + 1, e, exp_data, rd);
            end
            n_vec++;
            if (obs_wen_lows !== ((!e && w) ? 1 : 0) || (!e && w && obs_wen_at !== lat_of(d) + 1)) begin
                n_bad++;
                $display("FAIL rand_wen[%0d]: got %0d lows at %0d want %0d at %0d", t,
                         obs_wen_lows, obs_wen_at, (!e && w) ? 1 : 0, lat_of(d) + 1);
            end
            if (!e) begin
                n_vec++;
                if (obs_bus_first !== {a, sz, model_lanes(sz, wd)} || obs_bus_last !== {a, sz, model_lanes(sz, wd)}) begin
                    n_bad++;
                    $display("FAIL rand_bus[%0d]: got %h / %h want %h", t, obs_bus_first, obs_bus_last,
                             {a, sz, model_lanes(sz, wd)});
                end
            end
            repeat ($urandom_range(0, 2)) begin
                @(posedge CLK); #1;
            end
            n_vec++;
            if (resp_valid_o[d] !== 1'b1 || resp_data_o[d] !== exp_data) begin
                n_bad++;
                $display("FAIL rand_held[%0d]: got valid %b data %h want 1 %h", t, resp_valid_o[d], resp_data_o[d], exp_data);
            end
            handshake(d);
            n_vec++;
            if (req_ready_o[d] !== 1'b1 || resp_valid_o[d] !== 1'b0) begin
                n_bad++;
                $display("FAIL rand_idle[%0d]: got ready %b valid %b want 1 0", t, req_ready_o[d], resp_valid_o[d]);
            end
        end
        for (int i = 0; i < 512; i++) begin
            n_vec++;
            if (env_mem[i] !== ref_mem[i / 256][i % 256]) begin
                n_bad++;
                $display("FAIL mem_sweep[%0d]: got %h want %h", i, env_mem[i], ref_mem[i / 256][i % 256]);
            end
        end
    endtask

    initial begin
        req_valid_i[0] = 1'b0; req_valid_i[1] = 1'b0;
        resp_ready_i[0] = 1'b0; resp_ready_i[1] = 1'b0;
        req_wen = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'd0; req_wdata = 32'd0; req_rd = 5'd0;
        for (int i = 0; i < 256; i++) init_val[i] = 8'($urandom);
        init_val[8'h20] = 8'hA5;
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 256; i++) ref_mem[d][i] = init_val[i];

        test_reset();
        test_store_word();
        test_load_ext();
        test_errors();
        test_hold();
        test_reset_commit();
        test_random();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
